// File: rtl/apa102_read_arbiter_if.sv
// ----------------------------------------------------------------------------
// apa102_read_arbiter_if
//
// Purpose:
//   Groups the strip-driver request/return signals and the SPRAM read port
//   that the apa102_read_arbiter sits between.
//
// Signals:
//   read_request          per-driver level request, one bit per driver
//   read_address          per-driver read address, driver i at [i*AW +: AW]
//   read_data             shared returned word, valid while a strobe is high
//   read_finished_strobe  one-hot, one-cycle done pulse to the granted driver
//   mem_address           memory read address
//   mem_read_en           one-cycle memory read enable
//   mem_read_data         memory read data
//   busy                  arbiter has a read in progress
//
// Modports:
//   master  arbiter side (drives returns and the memory read port)
//   slave   driver/memory side
// ----------------------------------------------------------------------------
interface apa102_read_arbiter_if #(
    parameter int NUM_PORTS         = 4,
    parameter int ADDRESS_BUS_WIDTH = 16
);
    logic [NUM_PORTS-1:0]                   read_request;
    logic [NUM_PORTS*ADDRESS_BUS_WIDTH-1:0] read_address;
    logic [15:0]                            read_data;
    logic [NUM_PORTS-1:0]                   read_finished_strobe;
    logic [ADDRESS_BUS_WIDTH-1:0]           mem_address;
    logic                                   mem_read_en;
    logic [15:0]                            mem_read_data;
    logic                                   busy;

    modport master (
        input  read_request,
        input  read_address,
        input  mem_read_data,
        output read_data,
        output read_finished_strobe,
        output mem_address,
        output mem_read_en,
        output busy
    );

    modport slave (
        output read_request,
        output read_address,
        output mem_read_data,
        input  read_data,
        input  read_finished_strobe,
        input  mem_address,
        input  mem_read_en,
        input  busy
    );
endinterface

// File: rtl/apa102_read_arbiter.sv
// ----------------------------------------------------------------------------
// apa102_read_arbiter
//
// Purpose:
//   Shares one single-port pattern memory read port between several
//   apa102_out strip drivers. Requesters are granted one at a time, one
//   memory read is issued per grant, and the returned word goes back to the
//   granted driver together with a one-cycle done strobe.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    apa102_read_arbiter_if.master (requests, returns, memory port)
//
// Parameters:
//   NUM_PORTS          number of requesting drivers (2..8)
//   ADDRESS_BUS_WIDTH  read address width
//   READ_LATENCY       cycles from mem_read_en to valid mem_read_data (1..4)
//
// Configuration:
//   APA102_READ_ARBITER_PRIORITY_EN  when defined, the lowest-indexed
//   requester always wins; otherwise arbitration is round-robin.
// ----------------------------------------------------------------------------
module apa102_read_arbiter #(
    parameter int NUM_PORTS         = 4,
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int READ_LATENCY      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    apa102_read_arbiter_if.master bus
);

    localparam int IDXW = $clog2(NUM_PORTS);
    localparam int AW   = ADDRESS_BUS_WIDTH;
    // WAIT runs READ_LATENCY-1 cycles, so the counter is loaded with L-2.
    localparam logic [2:0] LAT_LOAD = (READ_LATENCY >= 2) ? 3'(READ_LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [IDXW-1:0]     r_winner;
    logic [IDXW-1:0]     w_sel;
    logic [AW-1:0]       r_address;
    logic [2:0]          r_lat_cnt;
    logic [15:0]         r_read_data;
    logic [NUM_PORTS-1:0] w_strobe;
    logic                w_any_req;
    logic                w_load;

    assign w_any_req = |bus.read_request;

`ifdef APA102_READ_ARBITER_PRIORITY_EN
    // Fixed priority: the lowest set request bit wins.
    always_comb begin
        w_sel = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (bus.read_request[i]) begin
                w_sel = IDXW'(i);
            end
        end
    end
`else
    logic [IDXW-1:0] r_last_grant;
    int              w_best;

    // Round-robin: pick the requester with the smallest distance from
    // last_grant+1, wrapping modulo NUM_PORTS.
    always_comb begin
        w_sel  = '0;
        w_best = NUM_PORTS;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (bus.read_request[i] &&
                (((i + NUM_PORTS - 1 - int'(r_last_grant)) % NUM_PORTS) < w_best)) begin
                w_best = (i + NUM_PORTS - 1 - int'(r_last_grant)) % NUM_PORTS;
                w_sel  = IDXW'(i);
            end
        end
    end

    // Reset value NUM_PORTS-1 makes port 0 the first winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= IDXW'(NUM_PORTS - 1);
        end else if (w_load) begin
            r_last_grant <= w_sel;
        end
    end
`endif

    // Next state; w_load marks a selection (from IDLE or straight out of
    // CAPTURE so sustained traffic never passes through IDLE).
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_load       = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next_state = (READ_LATENCY == 1) ? ST_CAPTURE : ST_WAIT;
            end
            ST_WAIT: begin
                if (r_lat_cnt == 3'd0) begin
                    w_next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (w_any_req) begin
                    w_load       = 1'b1;
                    w_next_state = ST_ISSUE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, grant/address capture, latency counter and data hold register.
    // The address is frozen at selection so an in-flight read is immune to
    // later address changes from the driver.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_winner    <= '0;
            r_address   <= '0;
            r_lat_cnt   <= 3'd0;
            r_read_data <= 16'h0000;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_winner  <= w_sel;
                r_address <= bus.read_address[w_sel*AW +: AW];
            end
            if (r_state == ST_ISSUE) begin
                r_lat_cnt <= LAT_LOAD;
            end else if ((r_state == ST_WAIT) && (r_lat_cnt != 3'd0)) begin
                r_lat_cnt <= r_lat_cnt - 3'd1;
            end
            if (r_state == ST_CAPTURE) begin
                r_read_data <= bus.mem_read_data;
            end
        end
    end

    // Strobe is decoded from CAPTURE so it lines up with the cycle the
    // memory word is valid; an async reset therefore cancels it at once.
    always_comb begin
        w_strobe = '0;
        if (r_state == ST_CAPTURE) begin
            w_strobe[r_winner] = 1'b1;
        end
    end

    // In CAPTURE the memory word is passed straight through so data and
    // strobe coincide; afterwards the registered copy holds it.
    assign bus.read_data            = (r_state == ST_CAPTURE) ? bus.mem_read_data : r_read_data;
    assign bus.read_finished_strobe = w_strobe;
    assign bus.mem_address          = r_address;
    assign bus.mem_read_en          = (r_state == ST_ISSUE);
    assign bus.busy                 = (r_state != ST_IDLE);

endmodule

// File: tb/tb_apa102_read_arbiter.sv
// ----------------------------------------------------------------------------
// tb_apa102_read_arbiter
//
// Two arbiter instances share clk/rst_n: index 0 has READ_LATENCY=1, index 1
// has READ_LATENCY=3. Each has a pipelined memory model. Directed scenarios
// are followed by randomized traffic checked against a transaction-level
// model (age of the in-flight read plus a round-robin pointer).
// ----------------------------------------------------------------------------
module tb_apa102_read_arbiter;

    localparam int NP = 4;
    localparam int AW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [NP-1:0]    tbReq  [0:1];
    logic [NP*AW-1:0] tbAddr [0:1];

    logic [15:0] memPipe1 = 16'h0000;
    logic [15:0] memPipe3 [0:2] = '{default: 16'h0000};

    logic [NP-1:0] obsStrobe [0:1];
    logic [15:0]   obsData   [0:1];
    logic [AW-1:0] obsAddr   [0:1];
    logic          obsEn     [0:1];
    logic          obsBusy   [0:1];

    apa102_read_arbiter_if #(.NUM_PORTS(NP), .ADDRESS_BUS_WIDTH(AW)) ifc1 ();
    apa102_read_arbiter_if #(.NUM_PORTS(NP), .ADDRESS_BUS_WIDTH(AW)) ifc3 ();

    apa102_read_arbiter #(.NUM_PORTS(NP), .ADDRESS_BUS_WIDTH(AW), .READ_LATENCY(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc1)
    );

    apa102_read_arbiter #(.NUM_PORTS(NP), .ADDRESS_BUS_WIDTH(AW), .READ_LATENCY(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc3)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memFn(input logic [15:0] a);
        if (a == 16'h0123) return 16'hBEEF;
        return (a ^ 16'h5A5A) + 16'h1357;
    endfunction

    // Memory models: a read sampled on an edge shows up READ_LATENCY cycles
    // later; zero is returned when no read is in the pipe.
    always @(posedge clk) begin
        memPipe1    <= ifc1.mem_read_en ? memFn(ifc1.mem_address) : 16'h0000;
        memPipe3[0] <= ifc3.mem_read_en ? memFn(ifc3.mem_address) : 16'h0000;
        memPipe3[1] <= memPipe3[0];
        memPipe3[2] <= memPipe3[1];
    end

    assign ifc1.mem_read_data = memPipe1;
    assign ifc3.mem_read_data = memPipe3[2];
    assign ifc1.read_request  = tbReq[0];
    assign ifc3.read_request  = tbReq[1];
    assign ifc1.read_address  = tbAddr[0];
    assign ifc3.read_address  = tbAddr[1];

    assign obsStrobe[0] = ifc1.read_finished_strobe;
    assign obsStrobe[1] = ifc3.read_finished_strobe;
    assign obsData[0]   = ifc1.read_data;
    assign obsData[1]   = ifc3.read_data;
    assign obsAddr[0]   = ifc1.mem_address;
    assign obsAddr[1]   = ifc3.mem_address;
    assign obsEn[0]     = ifc1.mem_read_en;
    assign obsEn[1]     = ifc3.mem_read_en;
    assign obsBusy[0]   = ifc1.busy;
    assign obsBusy[1]   = ifc3.busy;

    // Reset pulse with all requests low; returns at a falling edge.
    task automatic applyReset();
        @(negedge clk);
        tbReq[0] = '0;
        tbReq[1] = '0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            tbReq[d]  = '1;
            tbAddr[d] = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obsEn[d] !== 1'b0) begin
                errors++; $display("[TB] FAIL reset_read_en dut%0d got %b expected 0", d, obsEn[d]);
            end
            checks++;
            if (obsAddr[d] !== 16'h0000) begin
                errors++; $display("[TB] FAIL reset_mem_address dut%0d got %h expected 0000", d, obsAddr[d]);
            end
            checks++;
            if (obsData[d] !== 16'h0000) begin
                errors++; $display("[TB] FAIL reset_read_data dut%0d got %h expected 0000", d, obsData[d]);
            end
            checks++;
            if (obsStrobe[d] !== 4'b0000) begin
                errors++; $display("[TB] FAIL reset_strobe dut%0d got %b expected 0000", d, obsStrobe[d]);
            end
            checks++;
            if (obsBusy[d] !== 1'b0) begin
                errors++; $display("[TB] FAIL reset_busy dut%0d got %b expected 0", d, obsBusy[d]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obsEn[d] !== 1'b1 || obsAddr[d] !== 16'h1000) begin
                errors++;
                $display("[TB] FAIL reset_first_grant dut%0d got en=%b addr=%h expected en=1 addr=1000",
                         d, obsEn[d], obsAddr[d]);
            end
        end
        tbReq[0] = '0;
        tbReq[1] = '0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_single_port();
        applyReset();
        tbAddr[0] = '0;
        tbAddr[0][2*AW +: AW] = 16'h0123;
        tbReq[0] = 4'b0100;
        @(negedge clk);
        checks++;
        if (obsEn[0] !== 1'b1 || obsAddr[0] !== 16'h0123 || obsStrobe[0] !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL single_issue got en=%b addr=%h strobe=%b expected en=1 addr=0123 strobe=0000",
                     obsEn[0], obsAddr[0], obsStrobe[0]);
        end
        tbReq[0] = '0;
        @(negedge clk);
        checks++;
        if (obsStrobe[0] !== 4'b0100 || obsData[0] !== 16'hBEEF || obsBusy[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_done got strobe=%b data=%h busy=%b expected strobe=0100 data=beef busy=1",
                     obsStrobe[0], obsData[0], obsBusy[0]);
        end
        @(negedge clk);
        checks++;
        if (obsStrobe[0] !== 4'b0000 || obsData[0] !== 16'hBEEF || obsBusy[0] !== 1'b0 || obsEn[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_hold got strobe=%b data=%h busy=%b en=%b expected 0000 beef 0 0",
                     obsStrobe[0], obsData[0], obsBusy[0], obsEn[0]);
        end
    endtask

    task automatic test_all_ports();
        int grantCount [NP];
        int expPort;
        applyReset();
        for (int p = 0; p < NP; p++) begin
            tbAddr[0][p*AW +: AW] = 16'h2000 + 16'(p);
            grantCount[p] = 0;
        end
        tbReq[0] = '1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
`ifdef APA102_READ_ARBITER_PRIORITY_EN
            expPort = 0;
`else
            expPort = ((k - 1) / 2) % NP;
`endif
            for (int p = 0; p < NP; p++) begin
                if (obsStrobe[0][p] === 1'b1) grantCount[p]++;
            end
            checks++;
            if (k % 2 == 1) begin
                if (obsEn[0] !== 1'b1 || obsAddr[0] !== (16'h2000 + 16'(expPort)) || obsStrobe[0] !== 4'b0000) begin
                    errors++;
                    $display("[TB] FAIL all_issue cycle %0d got en=%b addr=%h strobe=%b expected en=1 addr=%h strobe=0000",
                             k, obsEn[0], obsAddr[0], obsStrobe[0], 16'h2000 + 16'(expPort));
                end
            end else begin
                if (obsStrobe[0] !== (4'b0001 << expPort) || obsData[0] !== memFn(16'h2000 + 16'(expPort))) begin
                    errors++;
                    $display("[TB] FAIL all_strobe cycle %0d got strobe=%b data=%h expected strobe=%b data=%h",
                             k, obsStrobe[0], obsData[0], 4'b0001 << expPort, memFn(16'h2000 + 16'(expPort)));
                end
            end
        end
        for (int p = 0; p < NP; p++) begin
`ifdef APA102_READ_ARBITER_PRIORITY_EN
            expPort = (p == 0) ? 8 : 0;
`else
            expPort = 2;
`endif
            checks++;
            if (grantCount[p] != expPort) begin
                errors++;
                $display("[TB] FAIL all_grant_count port %0d got %0d expected %0d", p, grantCount[p], expPort);
            end
        end
        tbReq[0] = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_drop_mid();
        logic [NP-1:0] expStrobe;
        applyReset();
        tbAddr[1] = '0;
        tbAddr[1][1*AW +: AW] = 16'h3111;
        tbAddr[1][3*AW +: AW] = 16'h3333;
        tbReq[1] = 4'b0010;
        @(negedge clk);
        checks++;
        if (obsEn[1] !== 1'b1 || obsAddr[1] !== 16'h3111) begin
            errors++; $display("[TB] FAIL drop_issue got en=%b addr=%h expected en=1 addr=3111", obsEn[1], obsAddr[1]);
        end
        tbReq[1] = 4'b1000;
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            expStrobe = (k == 4) ? 4'b0010 : ((k == 8) ? 4'b1000 : 4'b0000);
            checks++;
            if (obsStrobe[1] !== expStrobe || obsEn[1] !== (k == 5)) begin
                errors++;
                $display("[TB] FAIL drop_seq cycle %0d got strobe=%b en=%b expected strobe=%b en=%b",
                         k, obsStrobe[1], obsEn[1], expStrobe, (k == 5));
            end
            if (k == 4) begin
                checks++;
                if (obsData[1] !== memFn(16'h3111)) begin
                    errors++; $display("[TB] FAIL drop_data got %h expected %h", obsData[1], memFn(16'h3111));
                end
            end
            if (k == 5) begin
                checks++;
                if (obsAddr[1] !== 16'h3333) begin
                    errors++; $display("[TB] FAIL drop_next_addr got %h expected 3333", obsAddr[1]);
                end
            end
        end
        tbReq[1] = '0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        applyReset();
        tbAddr[1] = '0;
        tbAddr[1][0*AW +: AW] = 16'h4000;
        tbAddr[1][2*AW +: AW] = 16'h4222;
        tbReq[1] = 4'b0100;
        @(negedge clk);
        checks++;
        if (obsEn[1] !== 1'b1 || obsAddr[1] !== 16'h4222) begin
            errors++; $display("[TB] FAIL rstmid_issue got en=%b addr=%h expected en=1 addr=4222", obsEn[1], obsAddr[1]);
        end
        @(negedge clk);
        tbReq[1] = '1;
        rst_n    = 1'b0;
        #1;
        checks++;
        if (obsBusy[1] !== 1'b0 || obsEn[1] !== 1'b0 || obsStrobe[1] !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL rstmid_abort got busy=%b en=%b strobe=%b expected 0 0 0000",
                     obsBusy[1], obsEn[1], obsStrobe[1]);
        end
        #1;
        rst_n = 1'b1;
        for (int k = 3; k <= 6; k++) begin
            @(negedge clk);
            if (k == 3) begin
                checks++;
                if (obsEn[1] !== 1'b1 || obsAddr[1] !== 16'h4000) begin
                    errors++; $display("[TB] FAIL rstmid_regrant got en=%b addr=%h expected en=1 addr=4000", obsEn[1], obsAddr[1]);
                end
            end
            checks++;
            if (obsStrobe[1] !== ((k == 6) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("[TB] FAIL rstmid_strobe cycle %0d got %b expected %b", k, obsStrobe[1], (k == 6) ? 4'b0001 : 4'b0000);
            end
        end
        tbReq[1] = '0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_addr_hold();
        applyReset();
        tbAddr[1] = '0;
        tbAddr[1][0*AW +: AW] = 16'h5001;
        tbReq[1] = 4'b0001;
        @(negedge clk);
        checks++;
        if (obsEn[1] !== 1'b1 || obsAddr[1] !== 16'h5001) begin
            errors++; $display("[TB] FAIL hold_issue got en=%b addr=%h expected en=1 addr=5001", obsEn[1], obsAddr[1]);
        end
        tbAddr[1][0*AW +: AW] = 16'h5002;
        for (int k = 2; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (obsAddr[1] !== 16'h5001) begin
                errors++; $display("[TB] FAIL hold_addr cycle %0d got %h expected 5001", k, obsAddr[1]);
            end
        end
        @(negedge clk);
        checks++;
        if (obsStrobe[1] !== 4'b0001 || obsData[1] !== memFn(16'h5001)) begin
            errors++;
            $display("[TB] FAIL hold_data got strobe=%b data=%h expected strobe=0001 data=%h",
                     obsStrobe[1], obsData[1], memFn(16'h5001));
        end
        @(negedge clk);
        checks++;
        if (obsEn[1] !== 1'b1 || obsAddr[1] !== 16'h5002) begin
            errors++; $display("[TB] FAIL hold_regrant got en=%b addr=%h expected en=1 addr=5002", obsEn[1], obsAddr[1]);
        end
        tbReq[1] = '0;
        repeat (5) @(negedge clk);
    endtask

    // Randomized traffic against a transaction model: 'age' counts cycles
    // since the grant edge; the read is issued at age 0 and returned at
    // age == latency, where the next winner may be chosen.
    task automatic test_random();
        for (int d = 0; d < 2; d++) begin
            int lat;
            bit inflight;
            int age;
            int last;
            int win;
            int pick;
            logic [15:0] mAddr;
            logic [15:0] mData;
            logic [NP-1:0] expStrobe;
            logic [15:0] expData;
            lat      = (d == 0) ? 1 : 3;
            inflight = 1'b0;
            age      = 0;
            last     = NP - 1;
            win      = 0;
            mAddr    = 16'h0000;
            mData    = 16'h0000;
            applyReset();
            for (int c = 0; c < 250; c++) begin
                expStrobe = (inflight && age == lat) ? (4'b0001 << win) : 4'b0000;
                expData   = (inflight && age == lat) ? memFn(mAddr) : mData;
                checks++;
                if (obsEn[d] !== (inflight && age == 0) || obsStrobe[d] !== expStrobe ||
                    obsData[d] !== expData || obsBusy[d] !== inflight || obsAddr[d] !== mAddr) begin
                    errors++;
                    $display("[TB] FAIL random dut%0d cycle %0d got en=%b strobe=%b data=%h busy=%b addr=%h expected en=%b strobe=%b data=%h busy=%b addr=%h",
                             d, c, obsEn[d], obsStrobe[d], obsData[d], obsBusy[d], obsAddr[d],
                             (inflight && age == 0), expStrobe, expData, inflight, mAddr);
                end
                tbReq[d]  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
                tbAddr[d] = {$urandom(), $urandom()};
                @(posedge clk);
                if (inflight && age == lat) mData = memFn(mAddr);
                if (!inflight || age == lat) begin
                    pick = -1;
`ifdef APA102_READ_ARBITER_PRIORITY_EN
                    for (int p = NP - 1; p >= 0; p--) begin
                        if (tbReq[d][p]) pick = p;
                    end
`else
                    for (int off = NP; off >= 1; off--) begin
                        if (tbReq[d][(last + off) % NP]) pick = (last + off) % NP;
                    end
`endif
                    if (pick >= 0) begin
                        inflight = 1'b1;
                        age      = 0;
                        win      = pick;
                        last     = pick;
                        mAddr    = tbAddr[d][pick*AW +: AW];
                    end else begin
                        inflight = 1'b0;
                    end
                end else begin
                    age++;
                end
                @(negedge clk);
            end
            tbReq[d] = '0;
            repeat (6) @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tbReq[0]  = '0;
        tbReq[1]  = '0;
        tbAddr[0] = '0;
        tbAddr[1] = '0;
        test_reset();
        test_single_port();
        test_all_ports();
        test_drop_mid();
        test_reset_mid();
        test_addr_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apa102_read_arbiter.md
# apa102_read_arbiter

Shares one single-port pattern memory read port between several `apa102_out` strip drivers. Each driver raises its read request whenever its word FIFO has room. The arbiter grants requesters round-robin, issues one memory read per grant and returns the word with a one-cycle done strobe to the granted driver only. It sits between the strip drivers and the SPRAM wrapper in the POV top level.

## Interface
- `NUM_PORTS`, 4, number of requesting strip drivers (2..8).
- `ADDRESS_BUS_WIDTH`, 16, width of read addresses.
- `READ_LATENCY`, 1, memory cycles from `mem_read_en` to valid `mem_read_data` (1..4).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `read_request`  in  NUM_PORTS  per-port level request, one bit per driver.
- `read_address`  in  NUM_PORTS*ADDRESS_BUS_WIDTH  per-port address, flattened; port i occupies bits [i*AW +: AW].
- `read_data`  out  16  shared returned word, valid while a strobe is high.
- `read_finished_strobe`  out  NUM_PORTS  one-hot, one-cycle pulse to the granted port.
- `mem_address`  out  ADDRESS_BUS_WIDTH  memory read address.
- `mem_read_en`  out  1  one-cycle memory read enable.
- `mem_read_data`  in  16  memory read data.
- `busy`  out  1  high from grant until the done strobe, inclusive.

## Operation
- FSM states:
  - IDLE: if any `read_request` bit is set, select a winner and go to ISSUE.
  - ISSUE: drive `mem_address` from the winner's address and `mem_read_en`=1. Then go to WAIT, or to CAPTURE when READ_LATENCY=1.
  - WAIT: decrement the latency counter; go to CAPTURE when it reaches 0.
  - CAPTURE: register `mem_read_data` into `read_data` and pulse the winner's strobe. Then go to ISSUE if any request is pending, otherwise go to IDLE.
- Round-robin selection:
  - The search starts at `last_grant+1` modulo NUM_PORTS and takes the first set bit.
  - `last_grant` updates when a port is selected.
  - After reset, `last_grant`=NUM_PORTS-1, so port 0 wins first.
- Selection for the next grant happens in the CAPTURE cycle, using the requests sampled in that cycle.
- The address is registered at selection. Later changes to the requester's address do not affect an in-flight read.
- If the granted port drops its request mid-transaction, the read still completes and the strobe is still pulsed. Drivers tolerate the surplus word.
- A request that is still high after its own strobe counts as a new request. It competes under round-robin and does not get a back-to-back grant unless it is the only requester.
- Only one read is ever in flight.

## Timing
- Reset values:
  - State IDLE.
  - `mem_read_en`=0, `mem_address`=0, `read_data`=0, `read_finished_strobe`=0, `busy`=0.
  - Latency counter=0.
- Reset asserted mid-transaction aborts the read; no strobe is emitted.
- Latency from a request seen in IDLE at edge N:
  - `mem_read_en` is high in cycle N+1.
  - The strobe and `read_data` are valid in cycle N+1+READ_LATENCY.
- Sustained throughput is one word per READ_LATENCY+1 cycles, shared among the active ports.
- `read_finished_strobe` is high for exactly one cycle, and at most one bit is set.
- `read_data` holds its value until the next CAPTURE.
- Strobes are in the `clk` domain. Drivers cross to the pixel-clock domain themselves.

## Configuration
- `APA102_READ_ARBITER_PRIORITY_EN` defined:
  - Fixed priority; the lowest-indexed requesting port always wins.
  - `last_grant` is unused.
- Not defined: round-robin as described above (default build).

## Test plan
- Reset with all requests high and `rst_n` low, then release → first `mem_read_en` is for port 0. Every output is 0 while reset is held.
- READ_LATENCY=1, only port 2 requesting `read_address`=0x0123, memory returns 0xBEEF → `mem_address`=0x0123, and `read_finished_strobe`=4'b0100 with `read_data`=0xBEEF two cycles after the request is seen.
- All four ports held high → grants cycle 0,1,2,3,0…, a strobe every 2 cycles, and no port starves. With PRIORITY_EN defined, only port 0 is ever granted.
- READ_LATENCY=3, port 1 drops its request the cycle after ISSUE → the strobe still arrives 3 cycles after `mem_read_en`, and no further grant goes to port 1.
- `rst_n` pulsed low during WAIT → no strobe is produced, state returns to IDLE, and the next grant goes to port 0.
- Port 0 changes its address during WAIT → `mem_address` keeps the value latched at grant.
